mdu_issue_ctrl: RTL and testbench

//   Initiator side of the E-stage MDU interface. Drives Start/MDUOP/ReadHILO/Time into the MDU.

---
 rtl/mdu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the MDU: combinational launch/decode, a local Busy mirror, and the D-stall.
// Optional watchdog on MDUBusy is compiled in with MDU_WATCHDOG_EN.
module mdu_issue_ctrl #(
    parameter logic [3:0] MULT_TIME  = 4'd5,
    parameter logic [3:0] DIV_TIME   = 4'd10,
    parameter logic [3:0] WDOG_LIMIT = 4'd12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_Valid,
    input  logic [3:0] E_MDUOP,
    input  logic [1:0] E_ReadHILO,
    input  logic       D_UsesMDU,
    input  logic       MDUBusy,
    output logic       Start,
    output logic [3:0] MDUOP,
    output logic [1:0] ReadHILO,
    output logic [3:0] Time,
    output logic       StallD,
    output logic       ProtoErr,
    output logic       Timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       perr_q, perr_d;
    logic       is_mult, is_div, is_md;

    always_comb begin
        is_mult  = E_Valid && (E_MDUOP == 4'b0001 || E_MDUOP == 4'b0010);
        is_div   = E_Valid && (E_MDUOP == 4'b0011 || E_MDUOP == 4'b0100);
        is_md    = is_mult || is_div;
        MDUOP    = E_Valid ? E_MDUOP : 4'd0;
        ReadHILO = E_Valid ? E_ReadHILO : 2'd0;
        Time     = is_mult ? MULT_TIME : (is_div ? DIV_TIME : 4'd0);
        Start    = is_md && (state_q == IDLE);
        StallD   = D_UsesMDU && (Start || state_q == WAIT);
    end

    // WAIT spans exactly the cycles the MDU reports Busy after the launch cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = WAIT;
                    cnt_d   = Time;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        perr_d = perr_q;
        if (is_md && state_q == WAIT)
            perr_d = 1'b1;
        if (MDUBusy && state_q == IDLE && !Start)
            perr_d = 1'b1;
        if (!MDUBusy && state_q == WAIT)
            perr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    assign ProtoErr = perr_q;

`ifdef MDU_WATCHDOG_EN
    logic [3:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        wdog_d    = MDUBusy ? ((wdog_q == 4'hF) ? wdog_q : wdog_q + 4'd1) : 4'd0;
        timeout_d = timeout_q || (wdog_d >= WDOG_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign Timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Randomized + directed bench for mdu_issue_ctrl against a queue-free occupancy model of the MDU.
module tb_mdu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       E_Valid;
    logic [3:0] E_MDUOP;
    logic [1:0] E_ReadHILO;
    logic       D_UsesMDU;
    logic       MDUBusy;
    logic       Start;
    logic [3:0] MDUOP;
    logic [1:0] ReadHILO;
    logic [3:0] Time;
    logic       StallD;
    logic       ProtoErr;
    logic       Timeout;

    mdu_issue_ctrl dut (
        .clk(clk), .reset(reset), .E_Valid(E_Valid), .E_MDUOP(E_MDUOP),
        .E_ReadHILO(E_ReadHILO), .D_UsesMDU(D_UsesMDU), .MDUBusy(MDUBusy),
        .Start(Start), .MDUOP(MDUOP), .ReadHILO(ReadHILO), .Time(Time),
        .StallD(StallD), .ProtoErr(ProtoErr), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: left = MDU busy cycles still owed after the launch cycle.
    int left = 0;
    int wd   = 0;
    bit perr = 1'b0;
    bit tmo  = 1'b0;
    int force_mode = 0;   // 0 ideal MDU, 1 Busy stuck high, 2 Busy stuck low

    function automatic bit is_md(input logic v, input logic [3:0] op);
        return v && (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic int t_of(input logic v, input logic [3:0] op);
        if (!v) return 0;
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic [3:0] op, input logic [1:0] rh, input logic d);
        int l;
        E_Valid    = v;
        E_MDUOP    = op;
        E_ReadHILO = rh;
        D_UsesMDU  = d;
        l = reset ? 0 : left;
        if (force_mode == 1)      MDUBusy = 1'b1;
        else if (force_mode == 2) MDUBusy = 1'b0;
        else                      MDUBusy = (is_md(v, op) && l == 0) || (l > 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        bit st;
        int nw;
        if (reset) begin
            left <= 0; wd <= 0; perr <= 1'b0; tmo <= 1'b0;
        end else begin
            st = is_md(E_Valid, E_MDUOP) && left == 0;
            if ((is_md(E_Valid, E_MDUOP) && left > 0) || (MDUBusy && left == 0 && !st) ||
                (!MDUBusy && left > 0))
                perr <= 1'b1;
            left <= st ? t_of(E_Valid, E_MDUOP) : ((left > 0) ? left - 1 : 0);
            nw = MDUBusy ? ((wd < 15) ? wd + 1 : 15) : 0;
            wd <= nw;
`ifdef MDU_WATCHDOG_EN
            if (nw >= 12) tmo <= 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        int l;
        bit st;
        l  = reset ? 0 : left;
        st = is_md(E_Valid, E_MDUOP) && l == 0;
        chk("start", Start, st);
        chk("mduop", MDUOP, E_Valid ? E_MDUOP : 4'd0);
        chk("readhilo", ReadHILO, E_Valid ? E_ReadHILO : 2'd0);
        if (E_Valid) chk("time", Time, t_of(E_Valid, E_MDUOP));
        chk("stalld", StallD, D_UsesMDU && (st || l > 0));
        chk("protoerr", ProtoErr, reset ? 1'b0 : perr);
        chk("timeout", Timeout, reset ? 1'b0 : tmo);
    end

    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd15};

    initial begin
        reset = 1'b1;
        apply(1'b0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        chk("rst_start", Start, 1'b0);
        chk("rst_stall", StallD, 1'b0);
        chk("rst_perr", ProtoErr, 1'b0);
        cyc();
        reset = 1'b0;
        apply(1'b0, 4'd0, 2'd0, 1'b0);

        // mthi while idle
        cyc(); apply(1'b1, 4'd5, 2'd0, 1'b1);
        @(negedge clk);
        chk("t3_mduop", MDUOP, 4'b0101);
        chk("t3_start", Start, 1'b0);
        chk("t3_stall", StallD, 1'b0);

        // mult, D held for the whole window
        cyc(); apply(1'b1, 4'd1, 2'd0, 1'b1);
        @(negedge clk);
        chk("t1_start", Start, 1'b1);
        chk("t1_time", Time, 4'd5);
        for (int i = 1; i <= 7; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b1);
            @(negedge clk);
            chk("t1_stall", StallD, (i <= 5) ? 1'b1 : 1'b0);
        end
        chk("t1_perr", ProtoErr, 1'b0);

        // divu with mflo waiting in D
        cyc(); apply(1'b1, 4'd4, 2'd0, 1'b1);
        @(negedge clk);
        chk("t2_time", Time, 4'd10);
        for (int i = 1; i <= 10; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b1);
            @(negedge clk);
            chk("t2_stall", StallD, 1'b1);
        end
        cyc(); apply(1'b1, 4'd0, 2'b01, 1'b0);
        @(negedge clk);
        chk("t2_stall_end", StallD, 1'b0);
        chk("t2_rhilo", ReadHILO, 2'b01);

        // reset in the middle of a div
        cyc(); apply(1'b1, 4'd3, 2'd0, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b1);
        end
        cyc(); reset = 1'b1; apply(1'b0, 4'd0, 2'd0, 1'b1);
        @(negedge clk);
        chk("t4_stall", StallD, 1'b0);
        cyc(); reset = 1'b0; apply(1'b1, 4'd1, 2'd0, 1'b0);
        @(negedge clk);
        chk("t4_start", Start, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
        end

        // legal random traffic: D-stall holds back MD ops while the MDU is busy
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            logic       v;
            cyc();
            v  = ($urandom % 4) != 0;
            op = ops[$urandom % 10];
            if (is_md(v, op) && left > 0) op = 4'd0;
            apply(v, op, 2'($urandom % 3), 1'($urandom));
        end
        @(negedge clk);
        chk("legal_perr", ProtoErr, 1'b0);

        // Busy lingers past a mult window
        for (int i = 0; i < 12; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
        end
        cyc(); reset = 1'b1; apply(1'b0, 4'd0, 2'd0, 1'b0);
        cyc(); reset = 1'b0; apply(1'b1, 4'd2, 2'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
        end
        @(negedge clk);
        chk("t5_perr_pre", ProtoErr, 1'b0);
        force_mode = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
        end
        force_mode = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
        end
        @(negedge clk);
        chk("t5_perr_sticky", ProtoErr, 1'b1);
        cyc(); reset = 1'b1; apply(1'b0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        chk("t5_perr_rst", ProtoErr, 1'b0);

        // Busy held high 12 cycles
        cyc(); reset = 1'b0; force_mode = 1; apply(1'b0, 4'd0, 2'd0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cyc(); apply(1'b0, 4'd0, 2'd0, 1'b0);
            @(negedge clk);
            if (i == 11) chk("t6_timeout_pre", Timeout, 1'b0);
        end
`ifdef MDU_WATCHDOG_EN
        chk("t6_timeout", Timeout, 1'b1);
`else
        chk("t6_timeout", Timeout, 1'b0);
`endif
        force_mode = 0;
        cyc(); reset = 1'b1; apply(1'b0, 4'd0, 2'd0, 1'b0);
        cyc(); reset = 1'b0; apply(1'b0, 4'd0, 2'd0, 1'b0);

        // unconstrained traffic with Busy faults and stray resets
        for (int i = 0; i < 400; i++) begin
            int r;
            cyc();
            r = int'($urandom % 24);
            force_mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            reset = (($urandom % 100) == 0);
            apply(1'($urandom % 4 != 0), ops[$urandom % 10], 2'($urandom % 3), 1'($urandom));
        end
        cyc(); reset = 1'b0; force_mode = 0; apply(1'b0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
